// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and helpers for the keypad number path: the key classification
//   enum, the builder FSM state enum, the 4x4 keymap and the decode_key function
//   that turns a latched active-low column/row pair into a key kind and value.
//   No ports; imported with "import keypad_pkg::*;".
//   Keymap encoding: digits 0-9 carry their own value, A-D are 4'hA-4'hD,
//   '*' is 4'hE and '#' is 4'hF.
package keypad_pkg;

    typedef enum logic [2:0] {
        DIGIT,
        OPER,
        CLEAR,
        ENTER,
        INVALID
    } key_kind_t;

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        HOLD
    } state_t;

    typedef struct packed {
        key_kind_t  kind;
        logic [3:0] value;
    } key_t;

    // Indexed [row][col]
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // True when exactly one bit of the code is low
    function automatic logic is_onehot_low(input logic [3:0] code);
        return ($countones(~code) == 1);
    endfunction

    // Position of the low bit; only meaningful when is_onehot_low holds
    function automatic logic [1:0] low_index(input logic [3:0] code);
        logic [1:0] idx;
        case (code)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Digits return their value, operators return 0..3 for A..D
    function automatic key_t decode_key(input logic [3:0] col, input logic [3:0] row);
        key_t       k;
        logic [3:0] code;
        k.kind  = INVALID;
        k.value = 4'h0;
        code    = 4'h0;
        if (is_onehot_low(col) && is_onehot_low(row)) begin
            code = KEYMAP[low_index(row)][low_index(col)];
            if (code <= 4'h9) begin
                k.kind  = DIGIT;
                k.value = code;
            end else if (code <= 4'hD) begin
                k.kind  = OPER;
                k.value = code - 4'hA;
            end else if (code == 4'hE) begin
                k.kind  = CLEAR;
            end else begin
                k.kind  = ENTER;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// keypad_key_decode
//   Purely combinational wrapper around decode_key so the same decode can be
//   shared with the display path. Registers nothing.
// Ports
//   col    in  4  active-low one-hot column code
//   row    in  4  active-low one-hot row code
//   kind   out    key classification (DIGIT/OPER/CLEAR/ENTER/INVALID)
//   value  out 4  digit value, or operator index 0..3 for A..D
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [3:0] col,
    input  logic [3:0] row,
    output key_kind_t  kind,
    output logic [3:0] value
);

    key_t key;

    assign key   = decode_key(col, row);
    assign kind  = key.kind;
    assign value = key.value;

endmodule

// File: rtl/keypad_number_builder.sv
// keypad_number_builder
//   Consumes the latched keypad event stream, accumulates up to N_DIGITS BCD
//   digits, converts the entry to binary one nibble per cycle on '#', and offers
//   the result on a valid/ready handshake. A-D keys become operator pulses.
//   Build option: KEYPAD_BACKSPACE_EN makes '*' a backspace instead of a clear.
// Ports
//   clk          in   1           system clock
//   rst          in   1           synchronous, active-low reset
//   colM         in   4           latched column code, active-low one-hot
//   rowM         in   4           latched row code, active-low one-hot
//   listoM       in   1           strobe: colM/rowM hold a new press
//   num_ready    in   1           downstream accepts num_bin
//   num_valid    out  1           num_bin valid, held until accepted
//   num_bin      out  BW          binary operand
//   digits_bcd   out  4*N_DIGITS  live entry, digit0 in the LS nibble
//   digit_count  out  3           digits entered
//   op_valid     out  1           pulse: operator key pressed
//   op_code      out  2           A=0 B=1 C=2 D=3
//   err_pulse    out  1           pulse: invalid code, overflow or dropped key
module keypad_number_builder
    import keypad_pkg::*;
#(
    parameter  int N_DIGITS = 3,
    localparam int BW       = $clog2(10**N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            colM,
    input  logic [3:0]            rowM,
    input  logic                  listoM,
    input  logic                  num_ready,
    output logic                  num_valid,
    output logic [BW-1:0]         num_bin,
    output logic [4*N_DIGITS-1:0] digits_bcd,
    output logic [2:0]            digit_count,
    output logic                  op_valid,
    output logic [1:0]            op_code,
    output logic                  err_pulse
);

    localparam int DW = 4 * N_DIGITS;

    state_t          state;
    logic            press_q;
    logic            drop_q;
    logic [3:0]      col_q;
    logic [3:0]      row_q;
    logic [BW-1:0]   acc;
    logic [2:0]      idx;

    key_kind_t       key_kind;
    logic [3:0]      key_val;
    logic [DW-1:0]   entry_shifted;
    logic [3:0]      nibble;
    logic [BW-1:0]   next_acc;

    keypad_key_decode u_decode (
        .col   (col_q),
        .row   (row_q),
        .kind  (key_kind),
        .value (key_val)
    );

    // Converter datapath: pick the nibble at idx and fold it into acc*10.
    // The result always fits in BW bits because the entry never exceeds
    // 10**N_DIGITS-1.
    always_comb begin
        entry_shifted = digits_bcd >> {idx, 2'b00};
        nibble        = entry_shifted[3:0];
        next_acc      = (acc << 3) + (acc << 1) + BW'(nibble);
    end

    // Press pipeline plus FSM. A strobe is captured on its own edge and acted on
    // one edge later. drop_q remembers that the strobe arrived while the FSM was
    // busy (including the accept edge, when the state was still HOLD), so it is
    // still dropped even though the FSM is back in COLLECT by the time it is
    // processed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= COLLECT;
            press_q     <= 1'b0;
            drop_q      <= 1'b0;
            col_q       <= 4'hF;
            row_q       <= 4'hF;
            acc         <= '0;
            idx         <= '0;
            num_valid   <= 1'b0;
            num_bin     <= '0;
            digits_bcd  <= '0;
            digit_count <= '0;
            op_valid    <= 1'b0;
            op_code     <= '0;
            err_pulse   <= 1'b0;
        end else begin
            press_q   <= listoM;
            col_q     <= colM;
            row_q     <= rowM;
            drop_q    <= listoM && (state != COLLECT);
            op_valid  <= 1'b0;
            err_pulse <= 1'b0;

            case (state)
                COLLECT: begin
                    if (press_q) begin
                        if (drop_q) begin
                            err_pulse <= 1'b1;
                        end else begin
                            case (key_kind)
                                DIGIT: begin
                                    if (digit_count == 3'(N_DIGITS)) begin
                                        err_pulse <= 1'b1;
                                    end else begin
                                        digits_bcd  <= (digits_bcd << 4) | DW'(key_val);
                                        digit_count <= digit_count + 3'd1;
                                    end
                                end
                                CLEAR: begin
`ifdef KEYPAD_BACKSPACE_EN
                                    if (digit_count != 3'd0) begin
                                        digits_bcd  <= digits_bcd >> 4;
                                        digit_count <= digit_count - 3'd1;
                                    end
`else
                                    digits_bcd  <= '0;
                                    digit_count <= '0;
`endif
                                end
                                OPER: begin
                                    op_valid <= 1'b1;
                                    op_code  <= key_val[1:0];
                                end
                                ENTER: begin
                                    if (digit_count != 3'd0) begin
                                        state <= CONVERT;
                                        acc   <= '0;
                                        idx   <= 3'(N_DIGITS - 1);
                                    end
                                end
                                default: begin
                                    err_pulse <= 1'b1;
                                end
                            endcase
                        end
                    end
                end

                CONVERT: begin
                    if (press_q) begin
                        err_pulse <= 1'b1;
                    end
                    acc <= next_acc;
                    if (idx == 3'd0) begin
                        state     <= HOLD;
                        num_valid <= 1'b1;
                        num_bin   <= next_acc;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end

                HOLD: begin
                    if (press_q) begin
                        err_pulse <= 1'b1;
                    end
                    if (num_valid && num_ready) begin
                        num_valid   <= 1'b0;
                        digits_bcd  <= '0;
                        digit_count <= '0;
                        state       <= COLLECT;
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_number_builder.sv
// tb_keypad_number_builder
//   Directed bench for keypad_number_builder. Stimulus pushes the expected
//   number, operator and error events (with the cycle they should appear) into
//   queues; a monitor on the falling edge pops and compares them as the DUT
//   presents them. Entry/count state is compared directly after each sequence.
//   Honours KEYPAD_BACKSPACE_EN for the '*' behaviour.
module tb_keypad_number_builder;

    localparam int N_DIGITS = 3;
    localparam int BW       = $clog2(10**N_DIGITS);

    typedef struct {
        int value;
        int cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            colM;
    logic [3:0]            rowM;
    logic                  listoM;
    logic                  num_ready;
    logic                  num_valid;
    logic [BW-1:0]         num_bin;
    logic [4*N_DIGITS-1:0] digits_bcd;
    logic [2:0]            digit_count;
    logic                  op_valid;
    logic [1:0]            op_code;
    logic                  err_pulse;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    logic num_valid_d = 1'b0;

    exp_t num_q[$];
    exp_t op_q[$];
    int   err_q[$];

    keypad_number_builder #(.N_DIGITS(N_DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .colM        (colM),
        .rowM        (rowM),
        .listoM      (listoM),
        .num_ready   (num_ready),
        .num_valid   (num_valid),
        .num_bin     (num_bin),
        .digits_bcd  (digits_bcd),
        .digit_count (digit_count),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        checks   = checks + 1;
        failures = failures + 1;
        $display("[TB] FAIL %s: event seen at cycle %0d, expected none", name, cycle);
    endtask

    // Drives one strobe with arbitrary codes and registers what it should cause
    task automatic applyRaw(input logic [3:0] c, input logic [3:0] r,
                            input int expErr, input int expOp, input int expNum);
        int d;
        @(posedge clk);
        #2;
        colM   = c;
        rowM   = r;
        listoM = 1'b1;
        d      = cycle;
        if (expErr != 0) err_q.push_back(d + 2);
        if (expOp >= 0)  op_q.push_back('{value: expOp, cyc: d + 2});
        if (expNum >= 0) num_q.push_back('{value: expNum, cyc: d + 2 + N_DIGITS});
        @(posedge clk);
        #2;
        listoM = 1'b0;
        colM   = 4'hF;
        rowM   = 4'hF;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int row, input int col,
                                 input int expErr, input int expOp, input int expNum);
        logic [3:0] c;
        logic [3:0] r;
        c = ~(4'b0001 << col);
        r = ~(4'b0001 << row);
        applyRaw(c, r, expErr, expOp, expNum);
    endtask

    task automatic checkEntry(input string name, input logic [31:0] bcd, input logic [31:0] cnt);
        checkOutput({name, "_bcd"}, 32'(digits_bcd), bcd);
        checkOutput({name, "_count"}, 32'(digit_count), cnt);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_digits_bcd"}, 32'(digits_bcd), 0);
        checkOutput({name, "_digit_count"}, 32'(digit_count), 0);
        checkOutput({name, "_num_bin"}, 32'(num_bin), 0);
        checkOutput({name, "_num_valid"}, 32'(num_valid), 0);
        checkOutput({name, "_op_valid"}, 32'(op_valid), 0);
        checkOutput({name, "_op_code"}, 32'(op_code), 0);
        checkOutput({name, "_err_pulse"}, 32'(err_pulse), 0);
    endtask

    // Monitor: compares each DUT event against the head of its queue
    always @(negedge clk) begin
        if (rst) begin
            if (num_valid && !num_valid_d) begin
                if (num_q.size() == 0) reportUnexpected("num_valid");
                else checkOutput("num_latency", cycle, num_q[0].cyc);
            end
            if (num_valid && num_ready) begin
                if (num_q.size() != 0) begin
                    exp_t e;
                    e = num_q.pop_front();
                    checkOutput("num_bin", 32'(num_bin), e.value);
                end
            end
            if (op_valid) begin
                if (op_q.size() == 0) reportUnexpected("op_valid");
                else begin
                    exp_t e;
                    e = op_q.pop_front();
                    checkOutput("op_cycle", cycle, e.cyc);
                    checkOutput("op_code", 32'(op_code), e.value);
                end
            end
            if (err_pulse) begin
                if (err_q.size() == 0) reportUnexpected("err_pulse");
                else begin
                    int ec;
                    ec = err_q.pop_front();
                    checkOutput("err_cycle", cycle, ec);
                end
            end
        end
        num_valid_d = num_valid;
    end

    initial begin
        int d;
        rst       = 1'b0;
        colM      = 4'hF;
        rowM      = 4'hF;
        listoM    = 1'b0;
        num_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Test 1: 1,2,3 then '#', downstream ready
        $display("[TB] test 1: 123#");
        num_ready = 1'b1;
        applyStimulus(0, 0, 0, -1, -1);
        applyStimulus(0, 1, 0, -1, -1);
        applyStimulus(0, 2, 0, -1, -1);
        checkEntry("t1_entry", 32'h123, 3);
        applyStimulus(3, 2, 0, -1, 123);
        repeat (6) @(negedge clk);
        checkEntry("t1_after_accept", 0, 0);
        checkOutput("t1_num_valid_low", 32'(num_valid), 0);

        // Test 2: overflow on the fourth digit
        $display("[TB] test 2: 9999#");
        applyStimulus(2, 2, 0, -1, -1);
        applyStimulus(2, 2, 0, -1, -1);
        applyStimulus(2, 2, 0, -1, -1);
        applyStimulus(2, 2, 1, -1, -1);
        checkEntry("t2_entry", 32'h999, 3);
        applyStimulus(3, 2, 0, -1, 999);
        repeat (6) @(negedge clk);
        checkEntry("t2_after_accept", 0, 0);

        // Test 3: 4,5,'*'
        $display("[TB] test 3: 45*");
        applyStimulus(1, 0, 0, -1, -1);
        applyStimulus(1, 1, 0, -1, -1);
        checkEntry("t3_before_star", 32'h045, 2);
        applyStimulus(3, 0, 0, -1, -1);
`ifdef KEYPAD_BACKSPACE_EN
        checkEntry("t3_backspace", 32'h004, 1);
        applyStimulus(3, 0, 0, -1, -1);
        checkEntry("t3_backspace2", 0, 0);
        applyStimulus(3, 0, 0, -1, -1);
        checkEntry("t3_backspace_empty", 0, 0);
`else
        checkEntry("t3_clear", 0, 0);
`endif

        // '#' with an empty entry is ignored silently
        applyStimulus(3, 2, 0, -1, -1);
        repeat (6) @(negedge clk);
        checkOutput("empty_enter_valid", 32'(num_valid), 0);

        // Test 4: invalid codes leave the entry untouched, then 'C'
        $display("[TB] test 4: invalid codes and operator");
        applyStimulus(1, 0, 0, -1, -1);
        applyRaw(4'b1100, 4'b1110, 1, -1, -1);
        applyRaw(4'b1110, 4'b1111, 1, -1, -1);
        checkEntry("t4_after_invalid", 32'h004, 1);
        applyStimulus(2, 3, 0, 2, -1);
        checkEntry("t4_after_op", 32'h004, 1);
        applyStimulus(3, 0, 0, -1, -1);
        checkEntry("t4_cleared", 0, 0);

        // Test 5: backpressure, press during HOLD, press on the accept edge
        $display("[TB] test 5: backpressure");
        num_ready = 1'b0;
        applyStimulus(2, 0, 0, -1, -1);
        applyStimulus(3, 2, 0, -1, 7);
        repeat (20) @(posedge clk);
        applyStimulus(0, 0, 1, -1, -1);
        checkEntry("t5_hold_entry", 32'h007, 1);
        checkOutput("t5_hold_valid", 32'(num_valid), 1);
        checkOutput("t5_hold_num", 32'(num_bin), 7);
        @(posedge clk);
        #2;
        num_ready = 1'b1;
        colM      = ~4'b0010;
        rowM      = ~4'b0001;
        listoM    = 1'b1;
        d         = cycle;
        err_q.push_back(d + 2);
        @(posedge clk);
        #2;
        listoM = 1'b0;
        colM   = 4'hF;
        rowM   = 4'hF;
        @(posedge clk);
        @(negedge clk);
        checkEntry("t5_after_accept", 0, 0);
        checkOutput("t5_valid_dropped", 32'(num_valid), 0);

        // Test 6: reset in the middle of a conversion
        $display("[TB] test 6: reset during convert");
        applyStimulus(0, 2, 0, -1, -1);
        applyStimulus(3, 2, 0, -1, -1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("t6_reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
        applyStimulus(1, 1, 0, -1, -1);
        checkEntry("t6_entry", 32'h005, 1);
        applyStimulus(3, 2, 0, -1, 5);

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; i < 50; i++) begin
            if (num_q.size() == 0 && op_q.size() == 0 && err_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        while (num_q.size() != 0) begin
            exp_t e;
            e = num_q.pop_front();
            checks   = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL num_missing: got no result, expected %0d at cycle %0d", e.value, e.cyc);
        end
        while (op_q.size() != 0) begin
            exp_t e;
            e = op_q.pop_front();
            checks   = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL op_missing: got no pulse, expected code %0d at cycle %0d", e.value, e.cyc);
        end
        while (err_q.size() != 0) begin
            int ec;
            ec = err_q.pop_front();
            checks   = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL err_missing: got no pulse, expected one at cycle %0d", ec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
